// File: rtl/weight_buffer_ctrl.sv
`default_nettype none
// weight_buffer_ctrl: loads DDR beats into weight-buffer rows and grants kernel-window reads that avoid rows still loading.
// Rev 1.0
module weight_buffer_ctrl #(
    parameter int ADDR_LEN     = 16,
    parameter int BUFFER_NUM   = 32,
    parameter int DDR_DATA_LEN = 256,
    parameter int DATA_LEN     = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic [ADDR_LEN-1:0]     load_base,
    input  logic [ADDR_LEN-1:0]     load_len,
    input  logic                    ddr_valid,
    output logic                    ddr_ready,
    input  logic [DDR_DATA_LEN-1:0] ddr_data,
    output logic [DDR_DATA_LEN-1:0] data_wr,
    output logic [ADDR_LEN-1:0]     wr_addr,
    output logic [BUFFER_NUM-1:0]   wr_en,
    output logic                    load_busy,
    output logic                    load_done,
    input  logic                    rd_req,
    input  logic [ADDR_LEN-1:0]     rd_addr,
    output logic                    rd_ack,
    output logic                    rd_conf,
    output logic [ADDR_LEN-1:0]     st_rd_addr,
    input  logic                    wb_ker_en,
    output logic                    ker_done,
    output logic [15:0]             ker_cnt
);
    localparam int GRP  = DDR_DATA_LEN / DATA_LEN;
    localparam int NGRP = BUFFER_NUM / GRP;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [ADDR_LEN-1:0] WIN_SPAN = ADDR_LEN'(9);

    typedef enum logic [0:0] {L_IDLE = 1'b0, L_RUN = 1'b1} l_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ISSUE = 2'd1, R_WAIT = 2'd2} r_state_t;

    l_state_t              l_state, l_next;
    r_state_t              r_state, r_next;
    logic [ADDR_LEN-1:0]   row, rows_left, end_row;
    logic [GW-1:0]         grp;
    logic [BUFFER_NUM-1:0] wr_en_nxt;
    logic [ADDR_LEN-1:0]   fwd_off, back_off, remain;
    logic                  beat, grp_last, last_beat, empty_load, accept_load;
    logic                  blocked, grant;

    assign ddr_ready   = (l_state == L_RUN);
    assign load_busy   = (l_state == L_RUN);
    assign beat        = ddr_valid && ddr_ready;
    assign grp_last    = (grp == GW'(NGRP - 1));
    assign last_beat   = beat && grp_last && (rows_left == ADDR_LEN'(1));
    assign accept_load = (l_state == L_IDLE) && load_start;
    assign empty_load  = accept_load && (load_len == '0);

    always_comb begin
        for (int i = 0; i < BUFFER_NUM; i++) begin
            wr_en_nxt[i] = (grp == GW'(i / GRP));
        end
    end

    always_comb begin
        l_next = l_state;
        case (l_state)
            L_IDLE:  if (accept_load && !empty_load) l_next = L_RUN;
            L_RUN:   if (last_beat) l_next = L_IDLE;
            default: l_next = L_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            l_state   <= L_IDLE;
            row       <= '0;
            rows_left <= '0;
            end_row   <= '0;
            grp       <= '0;
            data_wr   <= '0;
            wr_addr   <= '0;
            wr_en     <= '0;
            load_done <= 1'b0;
        end else begin
            l_state   <= l_next;
            load_done <= last_beat || empty_load;
            wr_en     <= beat ? wr_en_nxt : '0;
            if (beat) begin
                data_wr <= ddr_data;
                wr_addr <= row;
                if (grp_last) begin
                    grp       <= '0;
                    row       <= row + ADDR_LEN'(1);
                    rows_left <= rows_left - ADDR_LEN'(1);
                end else begin
                    grp <= grp + GW'(1);
                end
            end
            if (accept_load) begin
                row       <= load_base;
                rows_left <= load_len;
                end_row   <= load_base + load_len - ADDR_LEN'(1);
                grp       <= '0;
            end
        end
    end

    // Circular-interval overlap: either the pending range starts inside the
    // window, or the window starts inside the pending range.
    assign fwd_off  = row - rd_addr;
    assign back_off = rd_addr - row;
    assign remain   = end_row - row;
    assign blocked  = load_busy && ((fwd_off <= WIN_SPAN) || (back_off <= remain));

    always_comb begin
        r_next   = r_state;
        grant    = 1'b0;
        rd_conf  = 1'b0;
        rd_ack   = 1'b0;
        ker_done = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (rd_req && !blocked) begin
                    grant  = 1'b1;
                    r_next = R_ISSUE;
                end
            end
            R_ISSUE: begin
                rd_conf = 1'b1;
                rd_ack  = 1'b1;
                r_next  = R_WAIT;
            end
            R_WAIT: begin
                // Gated by rst_n so a read abandoned by reset never reports completion.
                ker_done = wb_ker_en && rst_n;
                if (wb_ker_en) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= R_IDLE;
            st_rd_addr <= '0;
            ker_cnt    <= '0;
        end else begin
            r_state <= r_next;
            if (grant) st_rd_addr <= rd_addr;
            if (ker_done) ker_cnt <= ker_cnt + 16'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_weight_buffer_ctrl.sv
`default_nettype none
// tb_weight_buffer_ctrl: scoreboard plus table-driven checks for weight_buffer_ctrl.
// Rev 1.0
module tb_weight_buffer_ctrl;
    localparam int AL = 16;
    localparam int BN = 32;
    localparam int DW = 256;

    logic          clk;
    logic          rst_n;
    logic          load_start;
    logic [AL-1:0] load_base, load_len;
    logic          ddr_valid, ddr_ready;
    logic [DW-1:0] ddr_data, data_wr;
    logic [AL-1:0] wr_addr;
    logic [BN-1:0] wr_en;
    logic          load_busy, load_done;
    logic          rd_req;
    logic [AL-1:0] rd_addr;
    logic          rd_ack, rd_conf;
    logic [AL-1:0] st_rd_addr;
    logic          wb_ker_en, ker_done;
    logic [15:0]   ker_cnt;

    weight_buffer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
        .load_len(load_len), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
        .ddr_data(ddr_data), .data_wr(data_wr), .wr_addr(wr_addr), .wr_en(wr_en),
        .load_busy(load_busy), .load_done(load_done), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_conf(rd_conf), .st_rd_addr(st_rd_addr),
        .wb_ker_en(wb_ker_en), .ker_done(ker_done), .ker_cnt(ker_cnt)
    );

    typedef struct {
        logic [AL-1:0] addr;
        logic [BN-1:0] mask;
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    typedef struct {
        logic [AL-1:0] base;
        logic [AL-1:0] len;
        logic [AL-1:0] ra;
        bit            blocked;
    } vec_t;

    exp_t          sbq[$];
    vec_t          vt[10];
    int            checks = 0;
    int            failures = 0;
    int            writes_seen = 0;
    int            done_cnt = 0;
    bit            pend_empty = 0;
    bit            have_last = 0;
    bit            prev_conf = 0;
    bit            early;
    logic [DW-1:0] last_data;
    logic [AL-1:0] last_addr;
    logic [AL-1:0] m_row, m_left;
    int            m_grp = 0;
    logic [15:0]   m_kcnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock: model what the DUT accepts at the edge, then check what it produced.
    task automatic step();
        exp_t e;
        bit   rst_edge;
        bit   exp_done;
        rst_edge = !rst_n;
        if (!rst_edge) begin
            if (load_start && !load_busy) begin
                if (load_len == '0) pend_empty = 1;
                else begin
                    m_row = load_base; m_left = load_len; m_grp = 0;
                end
            end
            if (ddr_valid && ddr_ready) begin
                e.addr = m_row;
                e.mask = 32'h0000000F << (4 * m_grp);
                e.data = ddr_data;
                e.last = (m_left == 1) && (m_grp == 7);
                sbq.push_back(e);
                if (m_grp == 7) begin
                    m_grp = 0; m_row = m_row + 1'b1; m_left = m_left - 1'b1;
                end else m_grp++;
            end
        end
        @(posedge clk);
        #1;
        if (rst_edge) begin
            chk("rst_wr_en", wr_en, 0);
            chk("rst_load_done", load_done, 0);
            sbq.delete();
            pend_empty = 0; have_last = 1; last_data = '0; last_addr = '0;
            prev_conf = 0; m_kcnt = 0;
            return;
        end
        exp_done = 0;
        if (wr_en != '0) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write actual=%0h required=0", wr_en);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_en", wr_en, e.mask);
                chk("data_wr", data_wr, e.data);
                exp_done = e.last;
                last_data = e.data; last_addr = e.addr; have_last = 1;
                writes_seen++;
            end
        end else if (have_last) begin
            chk("hold_data_wr", data_wr, last_data);
            chk("hold_wr_addr", wr_addr, last_addr);
        end
        if (sbq.size() != 0) begin
            checks++; failures++;
            $display("FAIL missing_write actual=none required=%0h", sbq[0].mask);
            sbq.delete();
        end
        if (pend_empty) begin
            exp_done = 1; pend_empty = 0;
        end
        chk("load_done", load_done, exp_done);
        if (load_done) done_cnt++;
        chk("rd_ack_eq_conf", rd_ack, rd_conf);
        if (prev_conf) chk("rd_conf_gap", rd_conf, 0);
        prev_conf = rd_conf;
    endtask

    task automatic do_reset();
        rst_n = 0; load_start = 0; ddr_valid = 0; rd_req = 0; wb_ker_en = 0;
        step(); step();
        rst_n = 1;
    endtask

    task automatic start_load(input logic [AL-1:0] b, input logic [AL-1:0] l);
        load_start = 1; load_base = b; load_len = l;
        step();
        load_start = 0;
    endtask

    task automatic run_load(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            ddr_data = rand256();
            step();
        end
        ddr_valid = 0;
    endtask

    initial begin
        vt[0] = '{100, 4, 95, 1};
        vt[1] = '{100, 4, 200, 0};
        vt[2] = '{100, 4, 90, 0};
        vt[3] = '{100, 4, 91, 1};
        vt[4] = '{100, 4, 103, 1};
        vt[5] = '{100, 4, 104, 0};
        vt[6] = '{16'd65534, 4, 2, 0};
        vt[7] = '{16'd65534, 4, 1, 1};
        vt[8] = '{5, 1, 16'd65535, 1};
        vt[9] = '{5, 1, 16'd65530, 0};

        load_base = 0; load_len = 0; ddr_data = '0; rd_addr = 0;
        do_reset();
        chk("reset_wr_en", wr_en, 0);
        chk("reset_data_wr", data_wr, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_busy_ready", {load_busy, ddr_ready, load_done}, 0);
        chk("reset_rd", {rd_ack, rd_conf, ker_done}, 0);
        chk("reset_st_rd_addr", st_rd_addr, 0);
        chk("reset_ker_cnt", ker_cnt, 0);

        // Two-row load with continuous valid.
        writes_seen = 0; done_cnt = 0;
        start_load(5, 2);
        chk("load_busy_run", load_busy, 1);
        ddr_valid = 1;
        run_load(40);
        chk("full_load_writes", writes_seen, 16);
        chk("full_load_done", done_cnt, 1);
        chk("full_load_idle", load_busy, 0);

        // Zero-length load.
        writes_seen = 0; done_cnt = 0;
        start_load(9, 0);
        chk("empty_load_done", done_cnt, 1);
        step(); step();
        chk("empty_load_writes", writes_seen, 0);
        chk("empty_load_busy", load_busy, 0);

        // Gapped valid.
        writes_seen = 0; done_cnt = 0;
        start_load(300, 1);
        for (int i = 0; i < 40 && done_cnt == 0; i++) begin
            ddr_valid = (i % 3 != 1);
            ddr_data  = rand256();
            step();
        end
        ddr_valid = 0;
        chk("gap_load_writes", writes_seen, 8);
        chk("gap_load_done", done_cnt, 1);

        // Overlap table.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            start_load(vt[v].base, vt[v].len);
            rd_req = 1; rd_addr = vt[v].ra;
            step();
            rd_req = 0;
            chk($sformatf("tbl%0d_rd_conf", v), rd_conf, !vt[v].blocked);
            if (!vt[v].blocked) chk($sformatf("tbl%0d_st_rd_addr", v), st_rd_addr, vt[v].ra);
        end

        // Blocked request released only after the load completes.
        do_reset();
        writes_seen = 0; done_cnt = 0; early = 0;
        start_load(100, 4);
        ddr_valid = 1; rd_req = 1; rd_addr = 95;
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            ddr_data = rand256();
            step();
            if (rd_conf) early = 1;
        end
        ddr_valid = 0;
        chk("blk_no_early_conf", early, 0);
        chk("blk_done", done_cnt, 1);
        chk("blk_writes", writes_seen, 32);
        step();
        rd_req = 0;
        chk("blk_conf_after_done", rd_conf, 1);
        chk("blk_st_rd_addr", st_rd_addr, 95);

        // Kernel completion and back-to-back request.
        do_reset();
        rd_req = 1; rd_addr = 0;
        step();
        rd_req = 0;
        chk("ker_first_conf", rd_conf, 1);
        for (int i = 0; i < 11; i++) begin
            step();
            chk("ker_no_early_done", ker_done, 0);
        end
        wb_ker_en = 1; rd_req = 1; rd_addr = 20;
        #1;
        chk("ker_done_pulse", ker_done, 1);
        m_kcnt++;
        step();
        wb_ker_en = 0;
        chk("ker_cnt_one", ker_cnt, m_kcnt);
        chk("b2b_not_yet", rd_conf, 0);
        step();
        rd_req = 0;
        chk("b2b_conf", rd_conf, 1);
        chk("b2b_st_rd_addr", st_rd_addr, 20);
        wb_ker_en = 1;
        #1;
        chk("ker_ignored_issue", ker_done, 0);
        wb_ker_en = 0;
        step();

        // Reset while waiting for the kernel.
        rst_n = 0; wb_ker_en = 1;
        #1;
        chk("ker_done_in_reset", ker_done, 0);
        step(); step();
        rst_n = 1;
        #1;
        chk("ker_ignored_after_reset", ker_done, 0);
        step();
        wb_ker_en = 0;
        chk("ker_cnt_after_reset", ker_cnt, 0);

        // Reset in the middle of a load, then restart.
        writes_seen = 0; done_cnt = 0;
        start_load(40, 2);
        ddr_valid = 1;
        for (int i = 0; i < 7; i++) begin
            ddr_data = rand256();
            step();
        end
        chk("mid_writes", writes_seen, 7);
        rst_n = 0;
        step();
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_busy", {load_busy, ddr_ready}, 0);
        step();
        rst_n = 1; ddr_valid = 0;
        step();
        writes_seen = 0; done_cnt = 0;
        start_load(40, 1);
        ddr_valid = 1;
        run_load(30);
        chk("restart_writes", writes_seen, 8);
        chk("restart_done", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
